// File: rtl/ysyx_210238_lsu_ua_pkg.sv
// Shared LSU definitions: ls_info bit indices, size codes,
// FSM encodings and the latched request bundle.
package ysyx_210238_lsu_ua_pkg;

  localparam int LS_LB  = 10;
  localparam int LS_LBU = 9;
  localparam int LS_LD  = 8;
  localparam int LS_LH  = 7;
  localparam int LS_LHU = 6;
  localparam int LS_LW  = 5;
  localparam int LS_LWU = 4;
  localparam int LS_SB  = 3;
  localparam int LS_SD  = 2;
  localparam int LS_SH  = 1;
  localparam int LS_SW  = 0;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [2:0] SZ_D = 3'd3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ0 = 3'd1;
  localparam logic [2:0] ST_REQ1 = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  typedef struct packed {
    logic        wr;
    logic [10:0] info;
    logic [63:0] wdata;
  } ls_req_t;

  function automatic logic [2:0] size_of(input logic [10:0] info);
    logic [2:0] s;
    s = SZ_B;
    if (info[LS_LH] | info[LS_LHU] | info[LS_SH])
      s = SZ_H;
    else if (info[LS_LW] | info[LS_LWU] | info[LS_SW])
      s = SZ_W;
    else if (info[LS_LD] | info[LS_SD])
      s = SZ_D;
    return s;
  endfunction

  function automatic logic [3:0] nbytes_of(input logic [2:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/ysyx_210238_lsu_ua_align.sv
// Byte-lane alignment: per-beat store strobes/data and
// load merge across two beats with sign/zero extension.
module ysyx_210238_lsu_ua_align
  import ysyx_210238_lsu_ua_pkg::*;
(
  input  logic [10:0] info,
  input  logic [2:0]  off,
  input  logic        hi,
  input  logic [63:0] wdata,
  input  logic [63:0] lo_data,
  input  logic [63:0] hi_data,
  output logic [7:0]  wstrb,
  output logic [63:0] beat_wdata,
  output logic [63:0] ld_data
);

  logic [3:0]   nb;
  logic [5:0]   sh;
  logic [15:0]  m16;
  logic [15:0]  strb16;
  logic [127:0] wd128;
  logic [63:0]  raw;

  assign nb     = nbytes_of(size_of(info));
  assign sh     = {off, 3'b000};
  assign m16    = (16'h1 << nb) - 16'h1;
  assign strb16 = m16 << off;
  assign wd128  = {64'h0, wdata} << sh;

  // Upper half of each 128-bit view is what spills into the second beat
  assign wstrb      = hi ? strb16[15:8] : strb16[7:0];
  assign beat_wdata = hi ? wd128[127:64] : wd128[63:0];
  assign raw        = 64'({hi_data, lo_data} >> sh);

  always_comb begin
    ld_data = raw;
    unique case (1'b1)
      info[LS_LB]:  ld_data = {{56{raw[7]}}, raw[7:0]};
      info[LS_LBU]: ld_data = {56'h0, raw[7:0]};
      info[LS_LH]:  ld_data = {{48{raw[15]}}, raw[15:0]};
      info[LS_LHU]: ld_data = {48'h0, raw[15:0]};
      info[LS_LW]:  ld_data = {{32{raw[31]}}, raw[31:0]};
      info[LS_LWU]: ld_data = {32'h0, raw[31:0]};
      default:      ld_data = raw;
    endcase
  end

endmodule

// File: rtl/ysyx_210238_lsu_ua.sv
// MEM-stage load/store unit with 8-byte boundary splitting
// or misalign trapping, stalling upstream via o_hold.
module ysyx_210238_lsu_ua
  import ysyx_210238_lsu_ua_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [63:0]       i_mem_wdata,
  input  logic [10:0]       i_ls_info,
  input  logic [63:0]       i_rd_data,
  input  logic [4:0]        i_rd_addr,
  input  logic              i_rd_wen,
  output logic              o_ram_valid,
  input  logic              i_ram_ready,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_wen,
  output logic [63:0]       o_ram_wdata,
  output logic [7:0]        o_ram_wstrb,
  output logic [2:0]        o_ram_size,
  input  logic [63:0]       i_ram_rdata,
  output logic [63:0]       o_rd_data,
  output logic [4:0]        o_rd_addr,
  output logic              o_rd_wen,
  output logic              o_mem_read,
  output logic [63:0]       o_mem_rdata,
  output logic              o_misalign,
  output logic              o_hold
);

  localparam logic [ADDR_W-1:0] BEAT = ADDR_W'(8);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  ls_req_t           req_q;
  logic [63:0]       buf0;
  logic [63:0]       rdata_q;

  logic        cen;
  logic        nat_in;
  logic [3:0]  nb_in;
  logic [3:0]  nb_q;
  logic        cross_q;
  logic        hi;
  logic        valid;
  logic [63:0] lo_data;
  logic [63:0] hi_data;
  logic [63:0] ld_data;

  assign cen     = (i_mem_read | i_mem_write) & (|i_ls_info);
  assign nb_in   = nbytes_of(size_of(i_ls_info));
  assign nat_in  = ({1'b0, i_mem_addr[2:0]} & (nb_in - 4'd1)) == 4'd0;
  assign nb_q    = nbytes_of(size_of(req_q.info));
  assign cross_q = ({1'b0, addr_q[2:0]} + nb_q) > 4'd8;
  assign hi      = state == ST_REQ1;
  assign valid   = (state == ST_REQ0) | hi;

  // Beat 0 is taken live when it is also the last beat
  assign lo_data = hi ? buf0 : i_ram_rdata;
  assign hi_data = hi ? i_ram_rdata : 64'h0;

  ysyx_210238_lsu_ua_align u_align (
    .info       (req_q.info),
    .off        (addr_q[2:0]),
    .hi         (hi),
    .wdata      (req_q.wdata),
    .lo_data    (lo_data),
    .hi_data    (hi_data),
    .wstrb      (o_ram_wstrb),
    .beat_wdata (o_ram_wdata),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      req_q   <= '0;
      buf0    <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (cen) begin
          addr_q <= i_mem_addr;
          req_q  <= '{wr: i_mem_write,
                      info: i_ls_info,
                      wdata: i_mem_wdata};
          state  <= (!nat_in && !MISALIGN_SPLIT) ?
                    ST_ERR : ST_REQ0;
        end
        ST_REQ0: if (i_ram_ready) begin
          buf0 <= i_ram_rdata;
          if (cross_q) begin
            state <= ST_REQ1;
          end else begin
            state <= ST_DONE;
            if (!req_q.wr) rdata_q <= ld_data;
          end
        end
        ST_REQ1: if (i_ram_ready) begin
          state <= ST_DONE;
          if (!req_q.wr) rdata_q <= ld_data;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_ram_valid = valid;
  assign o_ram_addr  = {addr_q[ADDR_W-1:3], 3'b000} +
                       (hi ? BEAT : '0);
  assign o_ram_wen   = valid & req_q.wr;
  assign o_ram_size  = cross_q ? SZ_D : size_of(req_q.info);
  assign o_rd_data   = i_rd_data;
  assign o_rd_addr   = i_rd_addr;
  assign o_mem_read  = i_mem_read;
  assign o_mem_rdata = rdata_q;
  assign o_misalign  = state == ST_ERR;
  assign o_hold      = cen & (state != ST_DONE) &
                       (state != ST_ERR);

  always_comb begin
    o_rd_wen = i_rd_wen;
    if (state == ST_ERR)
      o_rd_wen = 1'b0;
    else if (i_mem_write && (|i_ls_info))
      o_rd_wen = 1'b0;
    else if (i_mem_read && (|i_ls_info))
      o_rd_wen = state == ST_DONE;
  end

endmodule

// File: tb/tb_ysyx_210238_lsu_ua.sv
// Directed bench for the LSU: one split-mode and one
// trap-mode instance sharing the same stimulus.
module tb_ysyx_210238_lsu_ua;

  localparam logic [10:0] I_LB  = 11'h400;
  localparam logic [10:0] I_LD  = 11'h100;
  localparam logic [10:0] I_LH  = 11'h080;
  localparam logic [10:0] I_LHU = 11'h040;
  localparam logic [10:0] I_LW  = 11'h020;
  localparam logic [10:0] I_SD  = 11'h004;
  localparam logic [10:0] I_SH  = 11'h002;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_mem_read, i_mem_write;
  logic [63:0] i_mem_addr, i_mem_wdata;
  logic [10:0] i_ls_info;
  logic [63:0] i_rd_data;
  logic [4:0]  i_rd_addr;
  logic        i_rd_wen;
  logic        i_ram_ready;
  logic [63:0] i_ram_rdata;

  logic        a_valid, a_wen, a_rd_wen, a_mem_read;
  logic        a_mis, a_hold;
  logic [63:0] a_addr, a_wdata, a_rd_data, a_mem_rdata;
  logic [7:0]  a_wstrb;
  logic [2:0]  a_size;
  logic [4:0]  a_rd_addr;
  logic        b_valid, b_wen, b_rd_wen, b_mem_read;
  logic        b_mis, b_hold;
  logic [63:0] b_addr, b_wdata, b_rd_data, b_mem_rdata;
  logic [7:0]  b_wstrb;
  logic [2:0]  b_size;
  logic [4:0]  b_rd_addr;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ysyx_210238_lsu_ua #(.ADDR_W(64), .MISALIGN_SPLIT(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .i_ls_info(i_ls_info), .i_rd_data(i_rd_data),
    .i_rd_addr(i_rd_addr), .i_rd_wen(i_rd_wen),
    .o_ram_valid(a_valid), .i_ram_ready(i_ram_ready),
    .o_ram_addr(a_addr), .o_ram_wen(a_wen),
    .o_ram_wdata(a_wdata), .o_ram_wstrb(a_wstrb),
    .o_ram_size(a_size), .i_ram_rdata(i_ram_rdata),
    .o_rd_data(a_rd_data), .o_rd_addr(a_rd_addr),
    .o_rd_wen(a_rd_wen), .o_mem_read(a_mem_read),
    .o_mem_rdata(a_mem_rdata), .o_misalign(a_mis),
    .o_hold(a_hold)
  );

  ysyx_210238_lsu_ua #(.ADDR_W(64), .MISALIGN_SPLIT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .i_ls_info(i_ls_info), .i_rd_data(i_rd_data),
    .i_rd_addr(i_rd_addr), .i_rd_wen(i_rd_wen),
    .o_ram_valid(b_valid), .i_ram_ready(i_ram_ready),
    .o_ram_addr(b_addr), .o_ram_wen(b_wen),
    .o_ram_wdata(b_wdata), .o_ram_wstrb(b_wstrb),
    .o_ram_size(b_size), .i_ram_rdata(i_ram_rdata),
    .o_rd_data(b_rd_data), .o_rd_addr(b_rd_addr),
    .o_rd_wen(b_rd_wen), .o_mem_read(b_mem_read),
    .o_mem_rdata(b_mem_rdata), .o_misalign(b_mis),
    .o_hold(b_hold)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic rd, input logic wr,
                     input logic [63:0] addr,
                     input logic [63:0] wd,
                     input logic [10:0] info);
    i_mem_read  = rd;
    i_mem_write = wr;
    i_mem_addr  = addr;
    i_mem_wdata = wd;
    i_ls_info   = info;
  endtask

  task automatic drop();
    req(1'b0, 1'b0, 64'h0, 64'h0, 11'h0);
    i_rd_wen = 1'b0;
  endtask

  task automatic gap();
    drop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drop();
    i_rd_wen = 1'b1;
    i_rd_data = 64'hDEAD_BEEF_0000_1234;
    i_rd_addr = 5'd7;
    i_ram_ready = 1'b1;
    i_ram_rdata = 64'h0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (a_valid !== 1'b0 || a_hold !== 1'b0 || a_mis !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl got v=%b h=%b m=%b exp 0 0 0", a_valid, a_hold, a_mis);
    end
    checks++;
    if (a_mem_rdata !== 64'h0) begin
      fails++;
      $display("FAIL reset_rdata got=%h exp=0", a_mem_rdata);
    end
    checks++;
    if (a_rd_wen !== 1'b1 || a_rd_data !== 64'hDEAD_BEEF_0000_1234 || a_rd_addr !== 5'd7) begin
      fails++;
      $display("FAIL passthru got wen=%b d=%h a=%0d exp 1 deadbeef00001234 7", a_rd_wen, a_rd_data, a_rd_addr);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_ignored();
    tick();
    req(1'b1, 1'b0, 64'h1000, 64'h0, 11'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (a_hold !== 1'b0 || a_valid !== 1'b0) begin
        fails++;
        $display("FAIL ignored_%0d got h=%b v=%b exp 0 0", i, a_hold, a_valid);
      end
      tick();
    end
    drop();
  endtask

  task automatic test_sd_aligned();
    tick();
    req(1'b0, 1'b1, 64'h1000, 64'h1122334455667788, I_SD);
    i_ram_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (a_hold !== 1'b1 || a_valid !== 1'b0) begin
      fails++;
      $display("FAIL sd_capture got h=%b v=%b exp 1 0", a_hold, a_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (a_valid !== 1'b1 || a_addr !== 64'h1000 || a_wstrb !== 8'hFF || a_size !== 3'd3 || a_wen !== 1'b1) begin
      fails++;
      $display("FAIL sd_beat got v=%b a=%h s=%h z=%0d w=%b exp 1 1000 ff 3 1", a_valid, a_addr, a_wstrb, a_size, a_wen);
    end
    checks++;
    if (a_wdata !== 64'h1122334455667788 || a_hold !== 1'b1) begin
      fails++;
      $display("FAIL sd_wdata got d=%h h=%b exp 1122334455667788 1", a_wdata, a_hold);
    end
    tick();
    @(negedge clk);
    checks++;
    if (a_hold !== 1'b0 || a_valid !== 1'b0 || a_rd_wen !== 1'b0) begin
      fails++;
      $display("FAIL sd_done got h=%b v=%b rw=%b exp 0 0 0", a_hold, a_valid, a_rd_wen);
    end
    tick();
    gap();
  endtask

  task automatic test_lb_sign();
    tick();
    req(1'b1, 1'b0, 64'h1003, 64'h0, I_LB);
    i_ram_rdata = 64'h0000_0000_8000_0000;
    @(negedge clk);
    checks++;
    if (a_rd_wen !== 1'b0) begin
      fails++;
      $display("FAIL lb_rdwen_idle got=%b exp=0", a_rd_wen);
    end
    tick();
    @(negedge clk);
    checks++;
    if (a_wstrb !== 8'h08 || a_addr !== 64'h1000 || a_size !== 3'd0 || a_wen !== 1'b0 || a_rd_wen !== 1'b0) begin
      fails++;
      $display("FAIL lb_beat got s=%h a=%h z=%0d w=%b rw=%b exp 08 1000 0 0 0", a_wstrb, a_addr, a_size, a_wen, a_rd_wen);
    end
    tick();
    @(negedge clk);
    checks++;
    if (a_mem_rdata !== 64'hFFFF_FFFF_FFFF_FF80 || a_rd_wen !== 1'b1 || a_hold !== 1'b0) begin
      fails++;
      $display("FAIL lb_done got d=%h rw=%b h=%b exp ffffffffffffff80 1 0", a_mem_rdata, a_rd_wen, a_hold);
    end
    tick();
    drop();
    @(negedge clk);
    checks++;
    if (a_rd_wen !== 1'b0) begin
      fails++;
      $display("FAIL lb_rdwen_after got=%b exp=0", a_rd_wen);
    end
    gap();
  endtask

  task automatic test_lw_split();
    tick();
    req(1'b1, 1'b0, 64'h1006, 64'h0, I_LW);
    tick();
    i_ram_rdata = 64'hBBAA_0000_0000_0000;
    @(negedge clk);
    checks++;
    if (a_valid !== 1'b1 || a_addr !== 64'h1000 || a_wstrb !== 8'hC0 || a_size !== 3'd3) begin
      fails++;
      $display("FAIL lw_beat0 got v=%b a=%h s=%h z=%0d exp 1 1000 c0 3", a_valid, a_addr, a_wstrb, a_size);
    end
    tick();
    i_ram_rdata = 64'h0000_0000_0000_DDCC;
    @(negedge clk);
    checks++;
    if (a_valid !== 1'b1 || a_addr !== 64'h1008 || a_wstrb !== 8'h03 || a_size !== 3'd3 || a_hold !== 1'b1) begin
      fails++;
      $display("FAIL lw_beat1 got v=%b a=%h s=%h z=%0d h=%b exp 1 1008 03 3 1", a_valid, a_addr, a_wstrb, a_size, a_hold);
    end
    tick();
    @(negedge clk);
    checks++;
    if (a_mem_rdata !== 64'hFFFF_FFFF_DDCC_BBAA || a_rd_wen !== 1'b1 || a_hold !== 1'b0) begin
      fails++;
      $display("FAIL lw_done got d=%h rw=%b h=%b exp ffffffffddccbbaa 1 0", a_mem_rdata, a_rd_wen, a_hold);
    end
    tick();
    gap();
  endtask

  task automatic test_sh_split();
    tick();
    req(1'b0, 1'b1, 64'h100F, 64'h0000_0000_0000_BEEF, I_SH);
    tick();
    @(negedge clk);
    checks++;
    if (a_addr !== 64'h1008 || a_wstrb !== 8'h80 || a_wdata !== 64'hEF00_0000_0000_0000 || a_wen !== 1'b1) begin
      fails++;
      $display("FAIL sh_beat0 got a=%h s=%h d=%h w=%b exp 1008 80 ef00000000000000 1", a_addr, a_wstrb, a_wdata, a_wen);
    end
    tick();
    @(negedge clk);
    checks++;
    if (a_addr !== 64'h1010 || a_wstrb !== 8'h01 || a_wdata !== 64'h0000_0000_0000_00BE || a_size !== 3'd3) begin
      fails++;
      $display("FAIL sh_beat1 got a=%h s=%h d=%h z=%0d exp 1010 01 be 3", a_addr, a_wstrb, a_wdata, a_size);
    end
    tick();
    @(negedge clk);
    checks++;
    if (a_hold !== 1'b0 || a_valid !== 1'b0) begin
      fails++;
      $display("FAIL sh_done got h=%b v=%b exp 0 0", a_hold, a_valid);
    end
    tick();
    gap();
  endtask

  task automatic test_misalign();
    tick();
    req(1'b1, 1'b0, 64'h1001, 64'h0, I_LH);
    @(negedge clk);
    checks++;
    if (b_hold !== 1'b1 || b_mis !== 1'b0) begin
      fails++;
      $display("FAIL mis_capture got h=%b m=%b exp 1 0", b_hold, b_mis);
    end
    tick();
    @(negedge clk);
    checks++;
    if (b_mis !== 1'b1 || b_hold !== 1'b0 || b_valid !== 1'b0 || b_rd_wen !== 1'b0) begin
      fails++;
      $display("FAIL mis_err got m=%b h=%b v=%b rw=%b exp 1 0 0 0", b_mis, b_hold, b_valid, b_rd_wen);
    end
    checks++;
    if (a_mis !== 1'b0 || a_valid !== 1'b1) begin
      fails++;
      $display("FAIL mis_split_ok got m=%b v=%b exp 0 1", a_mis, a_valid);
    end
    tick();
    drop();
    @(negedge clk);
    checks++;
    if (b_mis !== 1'b0 || b_valid !== 1'b0) begin
      fails++;
      $display("FAIL mis_pulse got m=%b v=%b exp 0 0", b_mis, b_valid);
    end
    gap();
  endtask

  task automatic test_back_to_back();
    tick();
    req(1'b1, 1'b0, 64'h3000, 64'h0, I_LD);
    i_ram_rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (a_mem_rdata !== 64'h0123_4567_89AB_CDEF || a_hold !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ld got d=%h h=%b exp 0123456789abcdef 0", a_mem_rdata, a_hold);
    end
    tick();
    req(1'b1, 1'b0, 64'h3002, 64'h0, I_LHU);
    @(negedge clk);
    checks++;
    if (a_hold !== 1'b1 || a_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_capture got h=%b v=%b exp 1 0", a_hold, a_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (a_wstrb !== 8'h0C || a_size !== 3'd1 || a_addr !== 64'h3000) begin
      fails++;
      $display("FAIL b2b_beat got s=%h z=%0d a=%h exp 0c 1 3000", a_wstrb, a_size, a_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (a_mem_rdata !== 64'h0000_0000_0000_89AB || a_rd_wen !== 1'b1) begin
      fails++;
      $display("FAIL b2b_lhu got d=%h rw=%b exp 89ab 1", a_mem_rdata, a_rd_wen);
    end
    tick();
    gap();
  endtask

  task automatic test_stall_reset();
    tick();
    req(1'b0, 1'b1, 64'h2000, 64'hCAFE_F00D_1234_5678, I_SD);
    i_ram_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if (a_valid !== 1'b1 || a_addr !== 64'h2000 || a_wstrb !== 8'hFF || a_wdata !== 64'hCAFE_F00D_1234_5678 || a_hold !== 1'b1) begin
        fails++;
        $display("FAIL stall_%0d got v=%b a=%h s=%h d=%h h=%b exp 1 2000 ff cafef00d12345678 1", i, a_valid, a_addr, a_wstrb, a_wdata, a_hold);
      end
    end
    tick();
    rst_n = 1'b0;
    drop();
    tick();
    @(negedge clk);
    checks++;
    if (a_valid !== 1'b0 || a_hold !== 1'b0 || a_mem_rdata !== 64'h0) begin
      fails++;
      $display("FAIL stall_reset got v=%b h=%b d=%h exp 0 0 0", a_valid, a_hold, a_mem_rdata);
    end
    tick();
    rst_n = 1'b1;
    i_ram_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_ignored();
    test_sd_aligned();
    test_lb_sign();
    test_lw_split();
    test_sh_split();
    test_misalign();
    test_back_to_back();
    test_stall_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
